// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the register-write hazard scoreboard:
// forwarding select codes, result source codes, Tnew/Tuse classes and the per-stage entry.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_E  = 2'b01,
        FWD_M  = 2'b10,
        FWD_W  = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_MEM  = 2'b01,
        SRC_PC8  = 2'b10,
        SRC_NONE = 2'b11
    } src_e;

    // Tnew is counted from entry into E; Tuse is counted from D.
    localparam logic [1:0] TNEW_JAL    = 2'd0;
    localparam logic [1:0] TNEW_ALU    = 2'd1;
    localparam logic [1:0] TNEW_LOAD   = 2'd2;
    localparam logic [1:0] TUSE_BRANCH = 2'd0;
    localparam logic [1:0] TUSE_ALU    = 2'd1;
    localparam logic [1:0] TUSE_STORE  = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [1:0] src;
    } entry_t;

    function automatic entry_t bubble_entry();
        entry_t e;
        e.valid = 1'b0;
        e.dst   = 5'd0;
        e.tnew  = 2'd0;
        e.src   = SRC_NONE;
        return e;
    endfunction

    function automatic entry_t age_entry(input entry_t e_in);
        entry_t e;
        e = e_in;
        if (e_in.tnew == 2'd0) begin
            e.tnew = 2'd0;
        end else begin
            e.tnew = e_in.tnew - 2'd1;
        end
        return e;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_operand_check.sv
// Per-operand hazard resolution: finds the youngest in-flight writer of the
// operand and applies the Tnew/Tuse rule to choose stall or a forwarding stage.
module hazard_operand_check
    import hazard_scoreboard_pkg::*;
(
    input  logic [4:0] addr,
    input  logic       used,
    input  logic [1:0] tuse,
    input  entry_t     e_entry,
    input  entry_t     m_entry,
    input  entry_t     w_entry,
    output logic       op_stall,
    output logic [1:0] sel
);

    logic       checked_s;
    logic       hit_e_s;
    logic       hit_m_s;
    logic       hit_w_s;
    logic       found_s;
    logic [1:0] cand_tnew_s;
    logic [1:0] cand_code_s;

    // Per-stage address match; register 0 is never a real dependency.
    always_comb begin
        checked_s = used && (addr != 5'd0);
        hit_e_s   = checked_s && e_entry.valid && (e_entry.dst == addr);
        hit_m_s   = checked_s && m_entry.valid && (m_entry.dst == addr);
        hit_w_s   = checked_s && w_entry.valid && (w_entry.dst == addr);
    end

    // Youngest match wins, even if an older matching stage is already ready.
    always_comb begin
        found_s     = 1'b0;
        cand_tnew_s = 2'd0;
        cand_code_s = FWD_RF;
        if (hit_e_s) begin
            found_s     = 1'b1;
            cand_tnew_s = e_entry.tnew;
            cand_code_s = FWD_E;
        end else if (hit_m_s) begin
            found_s     = 1'b1;
            cand_tnew_s = m_entry.tnew;
            cand_code_s = FWD_M;
        end else if (hit_w_s) begin
            found_s     = 1'b1;
            cand_tnew_s = w_entry.tnew;
            cand_code_s = FWD_W;
        end else begin
            found_s     = 1'b0;
            cand_tnew_s = 2'd0;
            cand_code_s = FWD_RF;
        end
    end

    // Tnew/Tuse decision; 0 < tnew <= tuse leaves the later-stage mux to pick the value up.
    always_comb begin
        op_stall = 1'b0;
        sel      = FWD_RF;
        if (!found_s) begin
            op_stall = 1'b0;
            sel      = FWD_RF;
        end else if (cand_tnew_s > tuse) begin
            op_stall = 1'b1;
            sel      = FWD_RF;
        end else if (cand_tnew_s == 2'd0) begin
            op_stall = 1'b0;
            sel      = cand_code_s;
        end else begin
            op_stall = 1'b0;
            sel      = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes through E/M/W and resolves D-stage
// operand hazards into stall/forward decisions, with a saturating stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [4:0]       issue_dst,
    input  logic [1:0]       issue_tnew,
    input  logic [1:0]       issue_src,
    input  logic [4:0]       rs_addr,
    input  logic             rs_used,
    input  logic [1:0]       rs_tuse,
    input  logic [4:0]       rt_addr,
    input  logic             rt_used,
    input  logic [1:0]       rt_tuse,
    output logic             stall,
    output logic [1:0]       fwd_rs_sel,
    output logic [1:0]       fwd_rt_sel,
    output logic [1:0]       e_src,
    output logic [1:0]       m_src,
    output logic [1:0]       w_src,
    output logic [CNT_W-1:0] stall_count
);

    entry_t           e_r;
    entry_t           m_r;
    entry_t           w_r;
    entry_t           e_next_s;
    logic             rs_stall_s;
    logic             rt_stall_s;
    logic             stall_s;
    logic [CNT_W-1:0] cnt_r;

    hazard_operand_check u_rs_check (
        .addr     (rs_addr),
        .used     (rs_used),
        .tuse     (rs_tuse),
        .e_entry  (e_r),
        .m_entry  (m_r),
        .w_entry  (w_r),
        .op_stall (rs_stall_s),
        .sel      (fwd_rs_sel)
    );

    hazard_operand_check u_rt_check (
        .addr     (rt_addr),
        .used     (rt_used),
        .tuse     (rt_tuse),
        .e_entry  (e_r),
        .m_entry  (m_r),
        .w_entry  (w_r),
        .op_stall (rt_stall_s),
        .sel      (fwd_rt_sel)
    );

    assign stall_s = rs_stall_s | rt_stall_s;

    // Stall and flush collapse into a single bubble entering E.
    always_comb begin
        e_next_s = bubble_entry();
        if (stall_s || flush) begin
            e_next_s = bubble_entry();
        end else begin
            e_next_s.valid = (issue_dst != 5'd0);
            e_next_s.dst   = issue_dst;
            e_next_s.tnew  = issue_tnew;
            e_next_s.src   = issue_src;
        end
    end

    // Write-descriptor shift pipeline E -> M -> W with Tnew counting down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_r <= bubble_entry();
            m_r <= bubble_entry();
            w_r <= bubble_entry();
        end else begin
            e_r <= e_next_s;
            m_r <= age_entry(e_r);
            w_r <= age_entry(m_r);
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign stall       = stall_s;
    assign e_src       = e_r.src;
    assign m_src       = m_r.src;
    assign w_src       = w_r.src;
    assign stall_count = cnt_r;

endmodule
